// File: rtl/hcr_stream_arbiter.sv
// ---------------------------------------------------------------------------
// hcr_stream_arbiter
//   Round-robin scheduler that multiplexes NUM_SRC user source FIFOs onto the
//   single 32-bit Xillybus host-read stream. Each grant emits one framing
//   header {A5, 0, gid, len} followed by up to MAX_BURST data words from the
//   granted source. Words are staged in an internal standard (non-FWFT) FIFO
//   whose read port connects straight to the core's hcr read interface.
//
// Ports
//   bus_clk, trn_reset_n        clock, synchronous active-low reset
//   user_r_hcr_rden/_data/_empty/_eof/_open   Xillybus hcr read interface
//   eof_req                     user request to signal end-of-file
//   src_enable/_empty/_count/_data            per-source FIFO status/data
//   src_rden                    per-source read strobe (one-hot or zero)
//   busy                        scheduler is mid-grant
// ---------------------------------------------------------------------------
module hcr_stream_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int MAX_BURST = 64,
    parameter int CNT_W     = 10,
    parameter int OUT_DEPTH = 16
) (
    input  logic                     bus_clk,
    input  logic                     trn_reset_n,
    input  logic                     user_r_hcr_rden,
    output logic [31:0]              user_r_hcr_data,
    output logic                     user_r_hcr_empty,
    output logic                     user_r_hcr_eof,
    input  logic                     user_r_hcr_open,
    input  logic                     eof_req,
    input  logic [NUM_SRC-1:0]       src_enable,
    input  logic [NUM_SRC-1:0]       src_empty,
    input  logic [NUM_SRC*CNT_W-1:0] src_count,
    input  logic [NUM_SRC*32-1:0]    src_data,
    output logic [NUM_SRC-1:0]       src_rden,
    output logic                     busy
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(OUT_DEPTH);
    localparam logic [SRC_W:0]   NSRC_C  = (SRC_W+1)'(NUM_SRC);
    localparam logic [SRC_W-1:0] LAST_C  = SRC_W'(NUM_SRC - 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [SRC_W-1:0] rr_q, rr_d;
    logic [SRC_W-1:0] gid_q, gid_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      issued_q, issued_d;
    logic [15:0]      written_q, written_d;
    logic             inflight_q;
    logic             eof_q;
    logic             open_q;

    // output FIFO
    logic [31:0]      mem [OUT_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [PTR_W:0]   cnt_q;
    logic [31:0]      rdata_q;

    // ---------------- eligibility and round-robin pick ----------------
    logic [NUM_SRC-1:0] elig;
    logic               found;
    logic [SRC_W-1:0]   sel;
    logic [SRC_W:0]     idx;
    logic [CNT_W-1:0]   sel_cnt;
    logic [15:0]        sel_len;
    logic [31:0]        src_word;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            elig[i] = src_enable[i] & ~src_empty[i] & (src_count[i*CNT_W +: CNT_W] != '0);
        end
    end

    // Walk rr, rr+1, ... modulo NUM_SRC; first eligible wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = {1'b0, rr_q} + (SRC_W+1)'(k);
            if (idx >= NSRC_C) idx = idx - NSRC_C;
            if (!found && elig[idx[SRC_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        sel_cnt  = '0;
        src_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SRC_W'(i))   sel_cnt  = src_count[i*CNT_W +: CNT_W];
            if (gid_q == SRC_W'(i)) src_word = src_data[i*32 +: 32];
        end
        if (32'(sel_cnt) > 32'(MAX_BURST)) sel_len = 16'(MAX_BURST);
        else                               sel_len = 16'(sel_cnt);
    end

    // ---------------- output FIFO control ----------------
    logic           fifo_full, fifo_empty, rd_fire, hdr_wr, wr_en, wr_ok, issue;
    logic [31:0]    wr_data;
    logic [PTR_W:0] occ;

    assign fifo_full  = (cnt_q == DEPTH_C);
    assign fifo_empty = (cnt_q == '0);
    assign rd_fire    = user_r_hcr_rden & ~fifo_empty;
    assign hdr_wr     = (state_q == S_HDR) & ~fifo_full;
    // Data words land one cycle after their src_rden; header and data never overlap.
    assign wr_en      = hdr_wr | inflight_q;
    assign wr_data    = hdr_wr ? {8'hA5, 4'h0, 4'(gid_q), len_q} : src_word;
    assign wr_ok      = wr_en & (~fifo_full | rd_fire);
    // Reserve a slot for the word already requested but not yet written.
    assign occ        = cnt_q + {{PTR_W{1'b0}}, inflight_q};
    assign issue      = (state_q == S_DATA) & (issued_q < len_q) & (occ < DEPTH_C);

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_rden[i] = issue & (gid_q == SRC_W'(i));
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gid_d     = gid_q;
        len_d     = len_q;
        issued_d  = issued_q;
        written_d = written_q;
        case (state_q)
            S_IDLE: begin
                if (user_r_hcr_open && found) begin
                    gid_d     = sel;
                    len_d     = sel_len;
                    issued_d  = '0;
                    written_d = '0;
                    state_d   = S_HDR;
                end
            end
            S_HDR: begin
                if (!fifo_full) state_d = S_DATA;
            end
            S_DATA: begin
                if (issue)      issued_d  = issued_q + 16'd1;
                if (inflight_q) written_d = written_q + 16'd1;
                if (written_q == len_q) state_d = S_DONE;
            end
            S_DONE: begin
                rr_d    = (gid_q == LAST_C) ? '0 : gid_q + SRC_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (!trn_reset_n) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            gid_q      <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            written_q  <= '0;
            inflight_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            eof_q      <= 1'b0;
            open_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            gid_q      <= gid_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            written_q  <= written_d;
            inflight_q <= issue;
            open_q     <= user_r_hcr_open;
            if (wr_ok)   wptr_q <= wptr_q + PTR_W'(1);
            if (rd_fire) begin
                rptr_q  <= rptr_q + PTR_W'(1);
                rdata_q <= mem[rptr_q];
            end
            case ({wr_ok, rd_fire})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            // Host closing the file wins over a pending set.
            if (open_q && !user_r_hcr_open)
                eof_q <= 1'b0;
            else if (eof_req && state_q == S_IDLE && fifo_empty)
                eof_q <= 1'b1;
        end
    end

    // Storage is not reset; pointers define what is valid.
    always_ff @(posedge bus_clk) begin
        if (wr_ok) mem[wptr_q] <= wr_data;
    end

    assign user_r_hcr_data  = rdata_q;
    assign user_r_hcr_empty = fifo_empty;
    assign user_r_hcr_eof   = eof_q;
    assign busy             = (state_q != S_IDLE);

endmodule
